// File: rtl/fdcp_reg.sv
// ---------------------------------------------------------------------------
// fdcp_reg
//
// Behavioural stand-in for the FDCP primitive: a bank of D flip-flops with
// an asynchronous clear and an asynchronous preset. The SDRAM controller uses
// it two ways: as an edge-captured request flag, and, with C tied low, as a
// set/reset latch.
//
// Parameters:
//   WIDTH - number of independent lanes (all share C, CLR and PRE)
//   INIT  - value of Q at time 0, before any clock, clear or preset
//
// Ports:
//   C   in  1      rising-edge clock (may be derived, inverted or tied 0)
//   CLR in  1      asynchronous clear, active-high, dominates PRE
//   PRE in  1      asynchronous preset, active-high, forces Q to all-ones
//   D   in  WIDTH  data captured on a rising C
//   Q   out WIDTH  registered output
//
// Priority: CLR -> Q=0; else PRE -> Q=all-ones; else rising C -> Q<=D;
// otherwise hold.
// ---------------------------------------------------------------------------
module fdcp_reg #(
  parameter int unsigned      WIDTH = 1,
  parameter logic [WIDTH-1:0] INIT  = {WIDTH{1'b0}}
) (
  input  logic             C,
  input  logic             CLR,
  input  logic             PRE,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  // Power-up value comes only from INIT; there is no other init path.
  logic [WIDTH-1:0] q_q = INIT;

  // Effective preset: PRE qualified by CLR being low. Its rising edge occurs
  // both when PRE asserts on its own and when CLR releases while PRE is still
  // held, so the flop reaches all-ones in that second case without a clock.
  logic pre_eff_s;
  assign pre_eff_s = PRE & ~CLR;

  // Lane storage: asynchronous clear (dominant), asynchronous preset, and
  // capture of D on rising C. An edge on C while either control is held
  // re-applies the forced value, so D is ignored.
  always_ff @(posedge C or posedge CLR or posedge pre_eff_s) begin
    if (CLR) begin
      q_q <= {WIDTH{1'b0}};
    end else if (pre_eff_s) begin
      q_q <= {WIDTH{1'b1}};
    end else begin
      q_q <= D;
    end
  end

  assign Q = q_q;

endmodule

// File: tb/tb_fdcp_reg.sv
`timescale 1ns/1ps
module tb_fdcp_reg;

  int errors = 0;
  int checks = 0;

  // Narrow (default) instance
  logic       c1, clr1, pre1;
  logic [0:0] d1, q1;

  // WIDTH=4 instance
  logic       c4, clr4, pre4;
  logic [3:0] d4, q4;

  // WIDTH=4 instance with a non-zero INIT, never stimulated
  logic       ci, clri, prei;
  logic [3:0] di, qi;

  fdcp_reg dut1 (.C(c1), .CLR(clr1), .PRE(pre1), .D(d1), .Q(q1));

  fdcp_reg #(.WIDTH(4)) dut4 (.C(c4), .CLR(clr4), .PRE(pre4), .D(d4), .Q(q4));

  fdcp_reg #(.WIDTH(4), .INIT(4'b0110)) duti (.C(ci), .CLR(clri), .PRE(prei), .D(di), .Q(qi));

  initial begin
    c1 = 1'b0; clr1 = 1'b0; pre1 = 1'b0; d1 = 1'b0;
    c4 = 1'b0; clr4 = 1'b0; pre4 = 1'b0; d4 = 4'b0000;
    ci = 1'b0; clri = 1'b0; prei = 1'b0; di = 4'b1001;
  end

  // One full clock period on the narrow instance: rise, hold high, fall.
  task automatic pulse_c1();
    #2 c1 = 1'b1;
    #5 c1 = 1'b0;
    #3;
  endtask

  task automatic pulse_c4();
    #2 c4 = 1'b1;
    #5 c4 = 1'b0;
    #3;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (q1 !== 1'b0) begin
      errors++; $display("FAIL reset_init: Q=%b expected %b", q1, 1'b0);
    end
    checks++;
    if (q4 !== 4'b0000) begin
      errors++; $display("FAIL reset_init_w4: Q=%b expected %b", q4, 4'b0000);
    end
    checks++;
    if (qi !== 4'b0110) begin
      errors++; $display("FAIL reset_init_param: Q=%b expected %b", qi, 4'b0110);
    end
    clr1 = 1'b1; #1;
    checks++;
    if (q1 !== 1'b0) begin
      errors++; $display("FAIL reset_clr_held: Q=%b expected %b", q1, 1'b0);
    end
    clr1 = 1'b0; #1;
    checks++;
    if (q1 !== 1'b0) begin
      errors++; $display("FAIL reset_clr_released: Q=%b expected %b", q1, 1'b0);
    end
  endtask

  task automatic test_refresh_flag();
    d1 = 1'b0;
    pre1 = 1'b1; #1;
    checks++;
    if (q1 !== 1'b1) begin
      errors++; $display("FAIL flag_preset: Q=%b expected %b", q1, 1'b1);
    end
    pre1 = 1'b0; #1;
    #100; // ten idle clock periods with no edge on C
    checks++;
    if (q1 !== 1'b1) begin
      errors++; $display("FAIL flag_idle_hold: Q=%b expected %b", q1, 1'b1);
    end
    pulse_c1();
    checks++;
    if (q1 !== 1'b0) begin
      errors++; $display("FAIL flag_capture_0: Q=%b expected %b", q1, 1'b0);
    end
    d1 = 1'b1;
    pulse_c1();
    checks++;
    if (q1 !== 1'b1) begin
      errors++; $display("FAIL flag_capture_1: Q=%b expected %b", q1, 1'b1);
    end
  endtask

  task automatic test_priority();
    d1 = 1'b0;
    clr1 = 1'b1; pre1 = 1'b1; #1;
    checks++;
    if (q1 !== 1'b0) begin
      errors++; $display("FAIL prio_both: Q=%b expected %b", q1, 1'b0);
    end
    clr1 = 1'b0; #1;
    checks++;
    if (q1 !== 1'b1) begin
      errors++; $display("FAIL prio_clr_release: Q=%b expected %b", q1, 1'b1);
    end
    pre1 = 1'b0; #1;
    checks++;
    if (q1 !== 1'b1) begin
      errors++; $display("FAIL prio_pre_release: Q=%b expected %b", q1, 1'b1);
    end
  endtask

  task automatic test_clock_mask();
    pre1 = 1'b1; d1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pulse_c1();
      checks++;
      if (q1 !== 1'b1) begin
        errors++; $display("FAIL mask_pre_edge%0d: Q=%b expected %b", i, q1, 1'b1);
      end
    end
    pre1 = 1'b0; #1;
    clr1 = 1'b1; d1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pulse_c1();
      checks++;
      if (q1 !== 1'b0) begin
        errors++; $display("FAIL mask_clr_edge%0d: Q=%b expected %b", i, q1, 1'b0);
      end
    end
    clr1 = 1'b0; #1;
    checks++;
    if (q1 !== 1'b0) begin
      errors++; $display("FAIL mask_clr_release: Q=%b expected %b", q1, 1'b0);
    end
  endtask

  task automatic test_latch_mode();
    c1 = 1'b0;
    pre1 = 1'b1; #1; pre1 = 1'b0; #1;
    checks++;
    if (q1 !== 1'b1) begin
      errors++; $display("FAIL latch_set: Q=%b expected %b", q1, 1'b1);
    end
    d1 = 1'b0; #3; d1 = 1'b1; #3; d1 = 1'b0; #1;
    checks++;
    if (q1 !== 1'b1) begin
      errors++; $display("FAIL latch_d_ignored_set: Q=%b expected %b", q1, 1'b1);
    end
    clr1 = 1'b1; #1; clr1 = 1'b0; #1;
    checks++;
    if (q1 !== 1'b0) begin
      errors++; $display("FAIL latch_clear: Q=%b expected %b", q1, 1'b0);
    end
    d1 = 1'b1; #3; d1 = 1'b0; #3; d1 = 1'b1; #1;
    checks++;
    if (q1 !== 1'b0) begin
      errors++; $display("FAIL latch_d_ignored_clr: Q=%b expected %b", q1, 1'b0);
    end
    pre1 = 1'b1; #1; pre1 = 1'b0; #1;
    checks++;
    if (q1 !== 1'b1) begin
      errors++; $display("FAIL latch_set_again: Q=%b expected %b", q1, 1'b1);
    end
  endtask

  task automatic test_wide();
    d4 = 4'b1010;
    pulse_c4();
    checks++;
    if (q4 !== 4'b1010) begin
      errors++; $display("FAIL wide_capture_a: Q=%b expected %b", q4, 4'b1010);
    end
    d4 = 4'b0101;
    pulse_c4();
    checks++;
    if (q4 !== 4'b0101) begin
      errors++; $display("FAIL wide_capture_5: Q=%b expected %b", q4, 4'b0101);
    end
    pre4 = 1'b1; #1;
    checks++;
    if (q4 !== 4'b1111) begin
      errors++; $display("FAIL wide_preset: Q=%b expected %b", q4, 4'b1111);
    end
    pre4 = 1'b0; #1;
    checks++;
    if (q4 !== 4'b1111) begin
      errors++; $display("FAIL wide_preset_hold: Q=%b expected %b", q4, 4'b1111);
    end
    clr4 = 1'b1; #1;
    checks++;
    if (q4 !== 4'b0000) begin
      errors++; $display("FAIL wide_clear: Q=%b expected %b", q4, 4'b0000);
    end
    clr4 = 1'b0; #1;
    checks++;
    if (qi !== 4'b0110) begin
      errors++; $display("FAIL wide_init_untouched: Q=%b expected %b", qi, 4'b0110);
    end
  endtask

  initial begin
    test_reset();
    test_refresh_flag();
    test_priority();
    test_clock_mask();
    test_latch_mode();
    test_wide();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
